// File: rtl/codec_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : codec_init_sequencer
//  Purpose  : Launches the codec I2C register-init engine after a power-up
//             delay, supervises completion with a timeout and bounded retries
//             (separated by an idle gap), and reports sticky ok/fail status.
//             A re-init request from OK or FAIL restarts the launch without
//             repeating the power-up delay.
//  Options  : INIT_IN_SYNC_EN - when defined, init_done_in and reinit_req pass
//             through 2-flop synchronizers (2 cycles of extra input latency).
//  Revision : 1.0 - initial release
// ============================================================================
module codec_init_sequencer #(
    parameter int CNT_W            = 20,
    parameter int PWRUP_CYCLES     = 60000,
    parameter int TIMEOUT_CYCLES   = 1000000,
    parameter int RETRY_GAP_CYCLES = 1000,
    parameter int MAX_RETRY        = 3,
    parameter int RETRY_W          = 2
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               init_done_in,
    input  logic               reinit_req,
    output logic               init_go,
    output logic               init_busy,
    output logic               init_ok,
    output logic               init_fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         seq_state
);

    // Debug encoding of the state register is visible on seq_state.
    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_GO    = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_OK    = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    // Terminal counts: the shared counter starts at 0, so a phase of N cycles
    // ends when the counter reads N-1.
    localparam logic [CNT_W-1:0]   c_pwrup_last   = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_gap_last     = CNT_W'(RETRY_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_cnt_zero     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   c_cnt_one      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RETRY_W-1:0] c_max_retry    = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] c_retry_zero   = {RETRY_W{1'b0}};
    localparam logic [RETRY_W-1:0] c_retry_one    = {{(RETRY_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               go_q, go_d;
    logic               busy_q, busy_d;
    logic               ok_q, ok_d;
    logic               fail_q, fail_d;
    logic               done_q, done_d;

    logic               w_done_s;
    logic               w_reinit_s;
    logic               w_done_rise;
    logic               w_cnt_timeout;

`ifdef INIT_IN_SYNC_EN
    logic [1:0] done_sync_q, done_sync_d;
    logic [1:0] reinit_sync_q, reinit_sync_d;

    // Shift each asynchronous input one stage deeper into its synchronizer.
    always_comb begin
        done_sync_d   = {done_sync_q[0], init_done_in};
        reinit_sync_d = {reinit_sync_q[0], reinit_req};
    end

    // Synchronizer flops; they clear to 0 so nothing is requested at reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            done_sync_q   <= 2'b00;
            reinit_sync_q <= 2'b00;
        end else begin
            done_sync_q   <= done_sync_d;
            reinit_sync_q <= reinit_sync_d;
        end
    end

    assign w_done_s   = done_sync_q[1];
    assign w_reinit_s = reinit_sync_q[1];
`else
    assign w_done_s   = init_done_in;
    assign w_reinit_s = reinit_req;
`endif

    // done_q tracks the previous-cycle done level for edge detection.
    always_comb begin
        done_d = w_done_s;
    end

    // done_q resets high so a level already present at reset release is no edge.
    assign w_done_rise   = w_done_s & ~done_q;
    assign w_cnt_timeout = (cnt_q == c_timeout_last);

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_PWRUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, shared counter and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = c_cnt_zero;
        retry_d = retry_q;

        unique case (state_q)
            S_PWRUP: begin
                if (cnt_q == c_pwrup_last) begin
                    state_d = S_GO;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            S_GO: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A done edge on the timeout cycle still counts as success.
                if (w_done_rise) begin
                    state_d = S_OK;
                end else if (w_cnt_timeout) begin
                    if (retry_q == c_max_retry) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_GAP;
                        retry_d = retry_q + c_retry_one;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            S_GAP: begin
                if (cnt_q == c_gap_last) begin
                    state_d = S_GO;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            S_OK, S_FAIL: begin
                // Re-init skips the power-up delay and starts a fresh retry budget.
                if (w_reinit_s) begin
                    state_d = S_GO;
                    retry_d = c_retry_zero;
                end
            end

            default: begin
                state_d = S_PWRUP;
                retry_d = c_retry_zero;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        go_d   = (state_d == S_GO);
        ok_d   = (state_d == S_OK);
        fail_d = (state_d == S_FAIL);
        busy_d = !((state_d == S_OK) || (state_d == S_FAIL));
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q   <= c_cnt_zero;
            retry_q <= c_retry_zero;
            go_q    <= 1'b0;
            busy_q  <= 1'b1;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
        end
    end

    assign init_go   = go_q;
    assign init_busy = busy_q;
    assign init_ok   = ok_q;
    assign init_fail = fail_q;
    assign retry_cnt = retry_q;
    assign seq_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_codec_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_codec_init_sequencer
//  Purpose  : Self-checking bench for codec_init_sequencer. Each scenario is a
//             pre-planned done/reinit waveform; an event-level reference model
//             turns the plan into expected go/ok/fail events, and a monitor
//             compares those against what the DUT presents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_codec_init_sequencer;

    localparam int P    = 10;
    localparam int T    = 50;
    localparam int G    = 5;
    localparam int MR   = 2;
    localparam int S    = 1 + T + G;
    localparam int MAXE = 1024;
`ifdef INIT_IN_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    localparam int EV_GO   = 0;
    localparam int EV_OK   = 1;
    localparam int EV_FAIL = 2;

    logic       Clk          = 1'b0;
    logic       Rst_n        = 1'b0;
    logic       init_done_in = 1'b0;
    logic       reinit_req   = 1'b0;
    logic       init_go;
    logic       init_busy;
    logic       init_ok;
    logic       init_fail;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    codec_init_sequencer #(
        .CNT_W            (8),
        .PWRUP_CYCLES     (P),
        .TIMEOUT_CYCLES   (T),
        .RETRY_GAP_CYCLES (G),
        .MAX_RETRY        (MR),
        .RETRY_W          (2)
    ) u_dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .init_done_in (init_done_in),
        .reinit_req   (reinit_req),
        .init_go      (init_go),
        .init_busy    (init_busy),
        .init_ok      (init_ok),
        .init_fail    (init_fail),
        .retry_cnt    (retry_cnt),
        .seq_state    (seq_state)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int kind;
        int t;
        int retry;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc;

    // Plan, expressed as the level the sequencer sees internally at edge e.
    bit int_done   [0:MAXE-1];
    bit int_reinit [0:MAXE-1];

    // Edge index since reset release: after edge n, cyc == n.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic clear_plan();
        for (int i = 0; i < MAXE; i++) begin
            int_done[i]   = 1'b0;
            int_reinit[i] = 1'b0;
        end
    endtask

    task automatic set_done(input int a, input int b, input bit v);
        for (int i = a; i <= b && i < MAXE; i++) int_done[i] = v;
    endtask

    // Level at edge e and edge e-1; before the first edge done counts as high.
    function automatic bit rise_at(input int e);
        bit prev;
        prev = (e <= 1) ? 1'b1 : int_done[e-1];
        return int_done[e] && !prev;
    endfunction

    function automatic void push_ev(input int kind, input int t, input int k);
        ev_t x;
        x.kind  = kind;
        x.t     = t;
        x.retry = k;
        exp_q.push_back(x);
    endfunction

    // Event-level reference: go after the power-up delay, then per attempt a
    // T-edge window for a done rise, G-edge gaps, and reinit out of OK/FAIL.
    task automatic model(input int n);
        int t, k, g, r;
        bit found;
        t = P;
        k = 0;
        if (t > n) return;
        push_ev(EV_GO, t, k);
        while (1) begin
            g = t;
            found = 1'b0;
            for (int e = g + 2; e <= g + 1 + T && e <= n; e++) begin
                if (rise_at(e)) begin
                    found = 1'b1;
                    t = e;
                    break;
                end
            end
            if (found) begin
                push_ev(EV_OK, t, k);
            end else begin
                if (g + 1 + T > n) return;
                if (k == MR) begin
                    t = g + 1 + T;
                    push_ev(EV_FAIL, t, k);
                end else begin
                    k = k + 1;
                    t = g + 1 + T + G;
                    if (t > n) return;
                    push_ev(EV_GO, t, k);
                    continue;
                end
            end
            r = -1;
            for (int e = t + 1; e <= n; e++) begin
                if (int_reinit[e]) begin
                    r = e;
                    break;
                end
            end
            if (r < 0) return;
            t = r;
            k = 0;
            push_ev(EV_GO, t, k);
        end
    endtask

    task automatic check_reset(input string name);
        logic [8:0] act;
        act = {init_go, init_busy, init_ok, init_fail, retry_cnt, seq_state};
        checks++;
        if (act !== 9'b0_1_0_0_00_000) begin
            errors++;
            $display("FAIL %s_reset_values: got go=%b busy=%b ok=%b fail=%b retry=%0d state=%0d, required go=0 busy=1 ok=0 fail=0 retry=0 state=0",
                     name, init_go, init_busy, init_ok, init_fail, retry_cnt, seq_state);
        end
    endtask

    task automatic drive(input int e);
        init_done_in = (e + L < MAXE) ? int_done[e+L]   : 1'b0;
        reinit_req   = (e + L < MAXE) ? int_reinit[e+L] : 1'b0;
    endtask

    // Runs one plan for n edges after reset release, then aborts with reset.
    task automatic run_scenario(input string name, input int n);
        for (int i = 1; i <= L; i++) begin
            int_done[i]   = 1'b0;
            int_reinit[i] = 1'b0;
        end
        model(n);
        @(negedge Clk);
        drive(1);
        Rst_n = 1'b1;
        for (int e = 2; e <= n; e++) begin
            @(negedge Clk);
            drive(e);
        end
        @(negedge Clk);
        Rst_n        = 1'b0;
        init_done_in = 1'b0;
        reinit_req   = 1'b0;
        #1;
        check_reset(name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_events: %0d expected events never seen (next kind=%0d at cyc=%0d), required 0",
                     name, exp_q.size(), exp_q[0].kind, exp_q[0].t);
        end
        exp_q.delete();
        repeat (3) @(negedge Clk);
    endtask

    task automatic handle_event(input int kind);
        ev_t x;
        int  es;
        bit  eb, eo, ef;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, required no event", kind, cyc);
            return;
        end
        x  = exp_q.pop_front();
        es = (x.kind == EV_GO) ? 1 : (x.kind == EV_OK) ? 4 : 5;
        eb = (x.kind == EV_GO);
        eo = (x.kind == EV_OK);
        ef = (x.kind == EV_FAIL);
        if (kind != x.kind || cyc != x.t || int'(retry_cnt) != x.retry ||
            int'(seq_state) != es || init_busy != eb || init_ok != eo || init_fail != ef) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d retry=%0d state=%0d busy=%b ok=%b fail=%b, required kind=%0d cyc=%0d retry=%0d state=%0d busy=%b ok=%b fail=%b",
                     kind, cyc, retry_cnt, seq_state, init_busy, init_ok, init_fail,
                     x.kind, x.t, x.retry, es, eb, eo, ef);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge, outside reset.
    initial begin
        bit prev_ok, prev_fail, wait_chk;
        prev_ok   = 1'b0;
        prev_fail = 1'b0;
        wait_chk  = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (!Rst_n) begin
                prev_ok   = 1'b0;
                prev_fail = 1'b0;
                wait_chk  = 1'b0;
                continue;
            end
            checks++;
            if ((init_ok && init_fail) || (init_busy != !(init_ok || init_fail))) begin
                errors++;
                $display("FAIL status_invariant at cyc=%0d: got busy=%b ok=%b fail=%b, required busy=!(ok|fail) and not ok&fail",
                         cyc, init_busy, init_ok, init_fail);
            end
            if (wait_chk) begin
                checks++;
                if (init_go !== 1'b0 || seq_state !== 3'd2) begin
                    errors++;
                    $display("FAIL after_go at cyc=%0d: got go=%b state=%0d, required go=0 state=2",
                             cyc, init_go, seq_state);
                end
                wait_chk = 1'b0;
            end
            if (init_go) begin
                handle_event(EV_GO);
                wait_chk = 1'b1;
            end
            if (init_ok && !prev_ok)     handle_event(EV_OK);
            if (init_fail && !prev_fail) handle_event(EV_FAIL);
            prev_ok   = init_ok;
            prev_fail = init_fail;
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int d0, d1, e, e2, r, n, a, b, k, pd;
        bit v;

        repeat (2) @(negedge Clk);
        check_reset("initial");

        // Success on the first attempt, reinit ignored while busy, reinit from OK.
        clear_plan();
        d0 = int'($urandom_range(2, T));
        e  = P + 1 + d0;
        set_done(e, e + 1, 1'b1);
        int_reinit[5]     = 1'b1;
        int_reinit[P + 1] = 1'b1;
        int_reinit[P + 2] = 1'b1;
        r  = e + int'($urandom_range(3, 8));
        int_reinit[r] = 1'b1;
        d1 = int'($urandom_range(1, T));
        e2 = r + 1 + d1;
        set_done(e2, e2 + 3, 1'b1);
        run_scenario("ok_reinit", e2 + 10);

        // All attempts time out, then reinit from FAIL succeeds.
        clear_plan();
        r  = P + 2 * S + 1 + T + int'($urandom_range(1, 8));
        int_reinit[r] = 1'b1;
        d1 = int'($urandom_range(1, T));
        n  = r + 1 + T + 10;
        set_done(r + 1 + d1, n + L, 1'b1);
        run_scenario("fail_reinit", n);

        // Done high from reset is not an edge; only a later fall-then-rise counts.
        clear_plan();
        a = int'($urandom_range(1, 25));
        b = int'($urandom_range(a + 1, T));
        n = P + 1 + b + 8;
        set_done(1, P + a, 1'b1);
        set_done(P + 1 + b, n + L, 1'b1);
        int_reinit[P + 1 + a] = 1'b1;
        run_scenario("done_high", n);

        // Done rise exactly on the timeout edge: last retry, then a random attempt.
        for (int s = 0; s < 2; s++) begin
            clear_plan();
            k = (s == 0) ? MR : int'($urandom_range(0, MR));
            e = P + k * S + 1 + T;
            set_done(e, e + 2, 1'b1);
            run_scenario("timeout_edge", e + 8);
        end

        // Reset in the middle of the second WAIT; the next plan checks the restart.
        clear_plan();
        run_scenario("mid_wait_reset", P + S + 1 + int'($urandom_range(5, 40)));

        // Random done toggling and reinit pulses.
        for (int s = 0; s < 4; s++) begin
            clear_plan();
            pd = int'($urandom_range(15, 60));
            v  = 1'b0;
            for (int i = 1; i <= 400 + L; i++) begin
                if (($urandom % pd) == 0) v = !v;
                int_done[i]   = v;
                int_reinit[i] = (($urandom % 30) == 0);
            end
            run_scenario("random", 400);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
